// File: rtl/ecc_pkg.sv
// Shared SECDED(13,8) definitions: codeword geometry, bit positions and receiver states.
package ecc_pkg;

  localparam int unsigned CW_W      = 13;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SYN_W     = 4;
  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned LAST_POS  = CW_W - 1;

  // Hamming positions carrying d0..d7 and the four check bits.
  localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};
  localparam int unsigned CHK_POS  [SYN_W]  = '{1, 2, 4, 8};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DECODE,
    ST_HOLD
  } rx_state_t;

  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      d[i] = cw[DATA_POS[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/ecc_secded_dec.sv
// Combinational SECDED(13,8) decoder: syndrome, overall parity, correction and classification.
module ecc_secded_dec
  import ecc_pkg::*;
(
  input  logic [CW_W-1:0]   codeword,
  output logic [DATA_W-1:0] data,
  output logic              err_corrected,
  output logic              err_uncorrectable
);

  logic [SYN_W-1:0] syn;
  logic             parity_bad;
  logic [CW_W-1:0]  fixed;

  // Each syndrome bit covers the positions whose index has that check bit set.
  always_comb begin
    syn = '0;
    for (int unsigned k = 0; k < SYN_W; k++) begin
      for (int unsigned i = 1; i < CW_W; i++) begin
        if ((i & CHK_POS[k]) != 0) begin
          syn[k] = syn[k] ^ codeword[i];
        end
      end
    end
  end

  assign parity_bad = ^codeword;

  always_comb begin
    fixed             = codeword;
    err_corrected     = 1'b0;
    err_uncorrectable = 1'b0;
    if (parity_bad) begin
      if (syn == '0) begin
        err_corrected = 1'b1;
      end else if (syn <= SYN_W'(LAST_POS)) begin
        fixed         = codeword ^ (CW_W'(1) << syn);
        err_corrected = 1'b1;
      end else begin
        err_uncorrectable = 1'b1;
      end
    end else if (syn != '0) begin
      err_uncorrectable = 1'b1;
    end
  end

  assign data = extract_data(fixed);

endmodule

// File: rtl/ecc_secded_receiver.sv
// Serial SECDED(13,8) receiver: shifts in a codeword, decodes it, holds the result for a consumer.
// Optional error counters are built when ECC_ERR_CNT_EN is defined.
module ecc_secded_receiver
  import ecc_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_bit,
  input  logic              rx_valid,
  input  logic              rx_sof,
  output logic              rx_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              err_corrected,
  output logic              err_uncorrectable,
  output logic              frame_abort
`ifdef ECC_ERR_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  rx_state_t            state, state_next;
  logic [CW_W-1:0]      cw_q, cw_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    data_out_d;
  logic                 data_valid_d, err_corrected_d, err_uncorrectable_d;
  logic                 frame_abort_d, rx_ready_d;
  logic                 xfer, handshake;
  logic [DATA_W-1:0]    dec_data;
  logic                 dec_corr, dec_uncorr;

  assign xfer      = rx_valid && rx_ready;
  assign handshake = data_valid && data_ready;

  ecc_secded_dec u_dec (
    .codeword          (cw_q),
    .data              (dec_data),
    .err_corrected     (dec_corr),
    .err_uncorrectable (dec_uncorr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (xfer && rx_sof) state_next = ST_SHIFT;
      ST_SHIFT:  if (xfer && !rx_sof && bit_cnt_q == BIT_CNT_W'(LAST_POS)) state_next = ST_DECODE;
      ST_DECODE: state_next = ST_HOLD;
      ST_HOLD:   if (handshake) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // data_valid rises one cycle into HOLD, after data_out and flags were loaded in DECODE.
  always_comb begin
    cw_d                = cw_q;
    bit_cnt_d           = bit_cnt_q;
    data_out_d          = data_out;
    err_corrected_d     = err_corrected;
    err_uncorrectable_d = err_uncorrectable;
    data_valid_d        = data_valid;
    frame_abort_d       = 1'b0;
    rx_ready_d          = (state_next == ST_IDLE) || (state_next == ST_SHIFT);
    unique case (state)
      ST_IDLE: begin
        if (xfer && rx_sof) begin
          cw_d[0]   = rx_bit;
          bit_cnt_d = BIT_CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          if (rx_sof) begin
            cw_d[0]       = rx_bit;
            bit_cnt_d     = BIT_CNT_W'(1);
            frame_abort_d = 1'b1;
          end else begin
            cw_d[bit_cnt_q] = rx_bit;
            bit_cnt_d       = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_DECODE: begin
        data_out_d          = dec_data;
        err_corrected_d     = dec_corr;
        err_uncorrectable_d = dec_uncorr;
        bit_cnt_d           = '0;
      end
      ST_HOLD: begin
        data_valid_d = !handshake;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_q              <= '0;
      bit_cnt_q         <= '0;
      data_out          <= '0;
      data_valid        <= 1'b0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
      frame_abort       <= 1'b0;
      rx_ready          <= 1'b1;
    end else begin
      cw_q              <= cw_d;
      bit_cnt_q         <= bit_cnt_d;
      data_out          <= data_out_d;
      data_valid        <= data_valid_d;
      err_corrected     <= err_corrected_d;
      err_uncorrectable <= err_uncorrectable_d;
      frame_abort       <= frame_abort_d;
      rx_ready          <= rx_ready_d;
    end
  end

`ifdef ECC_ERR_CNT_EN
  // Saturating per-class counters; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (state == ST_DECODE) begin
      if (dec_corr && (corr_cnt != '1))     corr_cnt   <= corr_cnt + CNT_W'(1);
      if (dec_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
